// File: rtl/alu_mc.sv
// Handshaked integer ALU: single-cycle base ops plus iterative shift-add multiply and
// restoring divide. One operation in flight; valid/ready on both request and result sides.
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       func,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             out_err
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;

    localparam logic [3:0] F_ZERO  = 4'd0;
    localparam logic [3:0] F_ADD   = 4'd1;
    localparam logic [3:0] F_SUB   = 4'd2;
    localparam logic [3:0] F_SLL   = 4'd3;
    localparam logic [3:0] F_SLT   = 4'd4;
    localparam logic [3:0] F_XOR   = 4'd5;
    localparam logic [3:0] F_OR    = 4'd6;
    localparam logic [3:0] F_AND   = 4'd7;
    localparam logic [3:0] F_SRL   = 4'd8;
    localparam logic [3:0] F_SRA   = 4'd9;
    localparam logic [3:0] F_SLTU  = 4'd10;
    localparam logic [3:0] F_MULU  = 4'd11;
    localparam logic [3:0] F_MULHU = 4'd12;
    localparam logic [3:0] F_DIVU  = 4'd13;
    localparam logic [3:0] F_REMU  = 4'd14;
    localparam logic [3:0] F_ILL   = 4'd15;

    localparam logic [SHW:0] CNT_DONE = (SHW+1)'(WIDTH);
    localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

    logic [1:0]         r_state;
    logic [SHW:0]       r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;
    logic [3:0]         r_func;
    logic [WIDTH-1:0]   r_result;
    logic               r_err;
    logic               r_out_valid;

    logic [1:0]         w_state_nxt;
    logic [SHW:0]       w_cnt_nxt;
    logic [2*WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0]   w_opnd_nxt;
    logic [3:0]         w_func_nxt;
    logic [WIDTH-1:0]   w_result_nxt;
    logic               w_err_nxt;
    logic               w_out_valid_nxt;

    logic               w_accept;
    logic               w_is_mul;
    logic               w_is_div;
    logic [SHW-1:0]     w_shamt;
    logic               w_slt;
    logic               w_sltu;
    logic [WIDTH-1:0]   w_alu;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_acc;
    logic [WIDTH:0]     w_div_trial;
    logic [2*WIDTH-1:0] w_div_acc;

    assign in_ready  = (r_state == S_IDLE) && (!r_out_valid || out_ready);
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign out_err   = r_err;

    assign w_accept = in_valid && in_ready;
    assign w_is_mul = (func == F_MULU) || (func == F_MULHU);
    assign w_is_div = (func == F_DIVU) || (func == F_REMU);
    assign w_shamt  = op2[SHW-1:0];
    assign w_slt    = $signed(op1) < $signed(op2);
    assign w_sltu   = op1 < op2;

    always_comb begin
        w_alu = '0;
        case (func)
            F_ZERO: w_alu = '0;
            F_ADD:  w_alu = op1 + op2;
            F_SUB:  w_alu = op1 - op2;
            F_SLL:  w_alu = op1 << w_shamt;
            F_SLT:  w_alu = {{(WIDTH-1){1'b0}}, w_slt};
            F_XOR:  w_alu = op1 ^ op2;
            F_OR:   w_alu = op1 | op2;
            F_AND:  w_alu = op1 & op2;
            F_SRL:  w_alu = op1 >> w_shamt;
            F_SRA:  w_alu = $signed(op1) >>> w_shamt;
            F_SLTU: w_alu = {{(WIDTH-1){1'b0}}, w_sltu};
            default: w_alu = '0;
        endcase
    end

    // Shift-add: acc = {partial product, remaining multiplier bits}, shifted right each step.
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_acc = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring divide: acc = {remainder, dividend/quotient}; a zero divisor never borrows,
    // which yields quotient all-ones and remainder = dividend without special casing.
    assign w_div_trial = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_opnd};
    assign w_div_acc   = w_div_trial[WIDTH]
                       ? {r_acc[2*WIDTH-2:0], 1'b0}
                       : {w_div_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_acc_nxt       = r_acc;
        w_opnd_nxt      = r_opnd;
        w_func_nxt      = r_func;
        w_result_nxt    = r_result;
        w_err_nxt       = r_err;
        w_out_valid_nxt = r_out_valid;

        if (r_out_valid && out_ready) begin
            w_out_valid_nxt = 1'b0;
        end

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_is_mul) begin
                        w_state_nxt = S_MUL;
                        w_cnt_nxt   = '0;
                        w_acc_nxt   = {{WIDTH{1'b0}}, op2};
                        w_opnd_nxt  = op1;
                        w_func_nxt  = func;
                    end else if (w_is_div) begin
                        w_state_nxt = S_DIV;
                        w_cnt_nxt   = '0;
                        w_acc_nxt   = {{WIDTH{1'b0}}, op1};
                        w_opnd_nxt  = op2;
                        w_func_nxt  = func;
                    end else begin
                        w_result_nxt    = w_alu;
                        w_err_nxt       = (func == F_ILL);
                        w_out_valid_nxt = 1'b1;
                    end
                end
            end
            S_MUL: begin
                if (r_cnt == CNT_DONE) begin
                    w_result_nxt    = (r_func == F_MULHU) ? r_acc[2*WIDTH-1:WIDTH]
                                                          : r_acc[WIDTH-1:0];
                    w_err_nxt       = 1'b0;
                    w_out_valid_nxt = 1'b1;
                    w_state_nxt     = S_IDLE;
                end else begin
                    w_acc_nxt = w_mul_acc;
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            S_DIV: begin
                if (r_cnt == CNT_DONE) begin
                    w_result_nxt    = (r_func == F_REMU) ? r_acc[2*WIDTH-1:WIDTH]
                                                         : r_acc[WIDTH-1:0];
                    w_err_nxt       = 1'b0;
                    w_out_valid_nxt = 1'b1;
                    w_state_nxt     = S_IDLE;
                end else begin
                    w_acc_nxt = w_div_acc;
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_opnd      <= '0;
            r_func      <= '0;
            r_result    <= '0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_acc       <= w_acc_nxt;
            r_opnd      <= w_opnd_nxt;
            r_func      <= w_func_nxt;
            r_result    <= w_result_nxt;
            r_err       <= w_err_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc: a 32-bit instance for the full op set and an
// 8-bit instance for the short multiply latency.
module tb_alu_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  func;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        out_err;

    logic        v8_in_valid;
    logic        v8_in_ready;
    logic [3:0]  v8_func;
    logic [7:0]  v8_op1;
    logic [7:0]  v8_op2;
    logic        v8_out_valid;
    logic        v8_out_ready;
    logic [7:0]  v8_result;
    logic        v8_out_err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(32)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .func      (func),
        .op1       (op1),
        .op2       (op2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .out_err   (out_err)
    );

    alu_mc #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v8_in_valid),
        .in_ready  (v8_in_ready),
        .func      (v8_func),
        .op1       (v8_op1),
        .op2       (v8_op2),
        .out_valid (v8_out_valid),
        .out_ready (v8_out_ready),
        .result    (v8_result),
        .out_err   (v8_out_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2;
        n_vec++; if (out_valid !== 1'b0) begin n_err++;
            $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_vec++; if (result !== 32'h0) begin n_err++;
            $display("FAIL reset_result: got %h want 00000000", result); end
        n_vec++; if (out_err !== 1'b0) begin n_err++;
            $display("FAIL reset_out_err: got %b want 0", out_err); end
        step();
        rst = 1'b1;
        step();
        n_vec++; if (in_ready !== 1'b1) begin n_err++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_single_cycle();
        logic [3:0]  t_f [12] = '{4'd1, 4'd2, 4'd9, 4'd4, 4'd10, 4'd3, 4'd8, 4'd5, 4'd6,
                                  4'd7, 4'd0, 4'd9};
        logic [31:0] t_a [12] = '{32'hFFFFFFFF, 32'h0, 32'h80000000, 32'hFFFFFFFF,
                                  32'hFFFFFFFF, 32'h1, 32'h80000000, 32'hF0F0F0F0,
                                  32'hF0F0F0F0, 32'hF0F0F0F0, 32'h1234, 32'h7FFFFFFF};
        logic [31:0] t_b [12] = '{32'h1, 32'h1, 32'h4, 32'h1, 32'h1, 32'h21, 32'h4,
                                  32'hFF00FF00, 32'h0000FFFF, 32'h0FF00FF0, 32'h5678,
                                  32'h1F};
        logic [31:0] t_e [12] = '{32'h0, 32'hFFFFFFFF, 32'hF8000000, 32'h1, 32'h0, 32'h2,
                                  32'h08000000, 32'h0FF00FF0, 32'hF0F0FFFF, 32'h00F000F0,
                                  32'h0, 32'h0};
        out_ready = 1'b1;
        in_valid  = 1'b1;
        func = t_f[0]; op1 = t_a[0]; op2 = t_b[0];
        for (int i = 0; i < 12; i++) begin
            step();
            n_vec++; if (out_valid !== 1'b1 || result !== t_e[i] || out_err !== 1'b0) begin
                n_err++;
                $display("FAIL single_%0d: got v=%b r=%h e=%b want v=1 r=%h e=0",
                         i, out_valid, result, out_err, t_e[i]);
            end
            if (i < 11) begin
                func = t_f[i+1]; op1 = t_a[i+1]; op2 = t_b[i+1];
            end else begin
                in_valid = 1'b0;
            end
        end
        step();
        n_vec++; if (out_valid !== 1'b0) begin n_err++;
            $display("FAIL single_retire: got %b want 0", out_valid); end
    endtask

    task automatic test_mul();
        logic [3:0]  t_f [4] = '{4'd11, 4'd12, 4'd11, 4'd12};
        logic [31:0] t_a [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h80000000};
        logic [31:0] t_b [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h4, 32'h4};
        logic [31:0] t_e [4] = '{32'h00000001, 32'hFFFFFFFE, 32'h0, 32'h2};
        int lat;
        logic rdy_seen;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; func = t_f[i]; op1 = t_a[i]; op2 = t_b[i];
            step();
            in_valid = 1'b0; op1 = $urandom; op2 = $urandom; func = 4'd1;
            lat = 0; rdy_seen = 1'b0;
            while (!out_valid && lat < 100) begin
                if (in_ready) rdy_seen = 1'b1;
                step();
                lat++;
            end
            n_vec++; if (lat != 33) begin n_err++;
                $display("FAIL mul_%0d_latency: got %0d want 33", i, lat); end
            n_vec++; if (rdy_seen !== 1'b0) begin n_err++;
                $display("FAIL mul_%0d_in_ready_busy: got 1 want 0", i); end
            n_vec++; if (result !== t_e[i] || out_err !== 1'b0) begin n_err++;
                $display("FAIL mul_%0d_result: got %h e=%b want %h e=0",
                         i, result, out_err, t_e[i]); end
            step();
        end
    endtask

    task automatic test_div();
        logic [3:0]  t_f [6] = '{4'd13, 4'd14, 4'd13, 4'd14, 4'd13, 4'd14};
        logic [31:0] t_a [6] = '{32'd100, 32'd100, 32'd5, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] t_b [6] = '{32'd7, 32'd7, 32'd0, 32'd0, 32'd10, 32'd10};
        logic [31:0] t_e [6] = '{32'd14, 32'd2, 32'hFFFFFFFF, 32'd5, 32'h19999999, 32'd5};
        int lat;
        logic rdy_seen;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; func = t_f[i]; op1 = t_a[i]; op2 = t_b[i];
            step();
            in_valid = 1'b0; op1 = $urandom; op2 = $urandom; func = 4'd2;
            lat = 0; rdy_seen = 1'b0;
            while (!out_valid && lat < 100) begin
                if (in_ready) rdy_seen = 1'b1;
                step();
                lat++;
            end
            n_vec++; if (lat != 33) begin n_err++;
                $display("FAIL div_%0d_latency: got %0d want 33", i, lat); end
            n_vec++; if (rdy_seen !== 1'b0) begin n_err++;
                $display("FAIL div_%0d_in_ready_busy: got 1 want 0", i); end
            n_vec++; if (result !== t_e[i] || out_err !== 1'b0) begin n_err++;
                $display("FAIL div_%0d_result: got %h e=%b want %h e=0",
                         i, result, out_err, t_e[i]); end
            step();
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; func = 4'd5; op1 = 32'h12345678; op2 = 32'hFFFF0000;
        step();
        n_vec++; if (out_valid !== 1'b1 || result !== 32'hEDCB5678) begin n_err++;
            $display("FAIL bp_xor: got v=%b r=%h want v=1 r=edcb5678", out_valid, result); end
        func = 4'd1; op1 = 32'h10; op2 = 32'h20;
        for (int c = 0; c < 4; c++) begin
            step();
            n_vec++;
            if (out_valid !== 1'b1 || result !== 32'hEDCB5678 || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold_%0d: got v=%b r=%h rdy=%b want v=1 r=edcb5678 rdy=0",
                         c, out_valid, result, in_ready);
            end
        end
        out_ready = 1'b1;
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++;
            $display("FAIL bp_ready_release: got %b want 1", in_ready); end
        step();
        n_vec++; if (out_valid !== 1'b1 || result !== 32'h30) begin n_err++;
            $display("FAIL bp_add: got v=%b r=%h want v=1 r=00000030", out_valid, result); end
        in_valid = 1'b0;
        step();
        n_vec++; if (out_valid !== 1'b0) begin n_err++;
            $display("FAIL bp_retire: got %b want 0", out_valid); end
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        in_valid = 1'b1; func = 4'd15; op1 = 32'h1234; op2 = 32'h5678;
        step();
        n_vec++; if (out_valid !== 1'b1 || result !== 32'h0 || out_err !== 1'b1) begin
            n_err++;
            $display("FAIL illegal: got v=%b r=%h e=%b want v=1 r=00000000 e=1",
                     out_valid, result, out_err);
        end
        func = 4'd7; op1 = 32'hFF00; op2 = 32'h0FF0;
        step();
        n_vec++; if (out_valid !== 1'b1 || result !== 32'h0F00 || out_err !== 1'b0) begin
            n_err++;
            $display("FAIL illegal_then_and: got v=%b r=%h e=%b want v=1 r=00000f00 e=0",
                     out_valid, result, out_err);
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_mul_w8();
        logic [3:0] t_f [2] = '{4'd11, 4'd12};
        logic [7:0] t_e [2] = '{8'h01, 8'hFE};
        int lat;
        v8_out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            v8_in_valid = 1'b1; v8_func = t_f[i]; v8_op1 = 8'hFF; v8_op2 = 8'hFF;
            step();
            v8_in_valid = 1'b0; v8_op1 = 8'h00; v8_op2 = 8'h00;
            lat = 0;
            while (!v8_out_valid && lat < 50) begin
                step();
                lat++;
            end
            n_vec++; if (lat != 9) begin n_err++;
                $display("FAIL mul8_%0d_latency: got %0d want 9", i, lat); end
            n_vec++; if (v8_result !== t_e[i] || v8_out_err !== 1'b0) begin n_err++;
                $display("FAIL mul8_%0d_result: got %h e=%b want %h e=0",
                         i, v8_result, v8_out_err, t_e[i]); end
            step();
        end
    endtask

    task automatic test_reset_mid_div();
        logic seen;
        out_ready = 1'b1;
        in_valid = 1'b1; func = 4'd13; op1 = 32'd100; op2 = 32'd7;
        step();
        in_valid = 1'b0;
        n_vec++; if (in_ready !== 1'b0) begin n_err++;
            $display("FAIL rstdiv_busy: got %b want 0", in_ready); end
        step(); step(); step();
        rst = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b0 || result !== 32'h0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rstdiv_during: got v=%b r=%h rdy=%b want v=0 r=00000000 rdy=1",
                     out_valid, result, in_ready);
        end
        step();
        rst = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        n_vec++; if (seen !== 1'b0) begin n_err++;
            $display("FAIL rstdiv_stale: got out_valid 1 want 0"); end
        n_vec++; if (result !== 32'h0 || in_ready !== 1'b1) begin n_err++;
            $display("FAIL rstdiv_after: got r=%h rdy=%b want r=00000000 rdy=1",
                     result, in_ready); end
    endtask

    initial begin
        in_valid = 1'b0; func = 4'd0; op1 = '0; op2 = '0; out_ready = 1'b1;
        v8_in_valid = 1'b0; v8_func = 4'd0; v8_op1 = '0; v8_op2 = '0; v8_out_ready = 1'b1;
        test_reset();
        test_single_cycle();
        test_mul();
        test_div();
        test_backpressure();
        test_illegal();
        test_mul_w8();
        test_reset_mid_div();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
